// File: rtl/cpl_tx_serializer.sv
// Completion TX serializer: streams a registered 3-DW completion header and
// then passes its payload straight through, one DW per transfer.
module cpl_tx_serializer #(
  parameter int LINK_NUMBER = 0,
  parameter int MAX_LEN     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] in_header,
  input  logic        in_header_valid,
  output logic        in_header_ready,
  input  logic [31:0] in_payload,
  input  logic        in_payload_valid,
  output logic        in_payload_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        len_error
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, PAYLOAD} state_e;

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  if (LINK_NUMBER < 0 || MAX_LEN < 1 || MAX_LEN > 1024) begin : g_param_check
    $error("cpl_tx_serializer: illegal LINK_NUMBER or MAX_LEN");
  end

  state_e      state_q, state_d;
  logic [95:0] hdr_q, hdr_d;
  logic [10:0] cnt_q, cnt_d;
  logic        len_err_q, len_err_d;
  logic        in_too_long;
  logic        hdr_with_data;

  // A Length field of zero encodes the maximum TLP payload of 1024 DW.
  function automatic logic [10:0] payloadCount(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  assign in_too_long   = in_header[30] && (payloadCount(in_header[9:0]) > MaxLen);
  assign hdr_with_data = hdr_q[30];

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_header_valid) begin
          if (in_too_long) begin
            len_err_d = 1'b1;
          end else begin
            hdr_d   = in_header;
            state_d = HDR0;
          end
        end
      end
      HDR0: if (out_ready) state_d = HDR1;
      HDR1: if (out_ready) state_d = HDR2;
      HDR2: begin
        if (out_ready) begin
          if (hdr_with_data) begin
            state_d = PAYLOAD;
            cnt_d   = payloadCount(hdr_q[9:0]);
          end else begin
            state_d = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (in_payload_valid && out_ready) begin
          if (cnt_q != 11'd0) cnt_d = cnt_q - 11'd1;
          if (cnt_q <= 11'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  // Outputs decode from state; gating with rst keeps them quiet for the whole
  // reset pulse, independent of any clock edge.
  always_comb begin
    in_header_ready  = 1'b0;
    in_payload_ready = 1'b0;
    out_valid        = 1'b0;
    out_data         = '0;
    out_sop          = 1'b0;
    out_eop          = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: in_header_ready = 1'b1;
        HDR0: begin
          out_valid = 1'b1;
          out_data  = hdr_q[31:0];
          out_sop   = 1'b1;
        end
        HDR1: begin
          out_valid = 1'b1;
          out_data  = hdr_q[63:32];
        end
        HDR2: begin
          out_valid = 1'b1;
          out_data  = hdr_q[95:64];
          out_eop   = !hdr_with_data;
        end
        PAYLOAD: begin
          in_payload_ready = out_ready;
          out_valid        = in_payload_valid;
          if (in_payload_valid) begin
            out_data = in_payload;
            out_eop  = (cnt_q == 11'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign len_error = len_err_q && !rst;

endmodule

// File: tb/tb_cpl_tx_serializer.sv
// Directed bench for cpl_tx_serializer: header/payload serialization,
// backpressure, length rejection and mid-TLP reset.
module tb_cpl_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_header;
  logic        in_header_valid;
  logic        in_header_ready;
  logic [31:0] in_payload;
  logic        in_payload_valid;
  logic        in_payload_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        len_error;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  cpl_tx_serializer #(
    .LINK_NUMBER(0),
    .MAX_LEN(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_header(in_header),
    .in_header_valid(in_header_valid),
    .in_header_ready(in_header_ready),
    .in_payload(in_payload),
    .in_payload_valid(in_payload_valid),
    .in_payload_ready(in_payload_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .len_error(len_error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectOut(input string tag, input logic v, input logic [31:0] d, input logic s, input logic e);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, "_data"}, out_data, d);
    checkOutput({tag, "_sop"}, 32'(out_sop), 32'(s));
    checkOutput({tag, "_eop"}, 32'(out_eop), 32'(e));
  endtask

  // Drives one complete TLP with out_ready held high; payload DW i is payBase+i.
  task automatic applyStimulus(input logic [95:0] h, input int nPay, input logic [31:0] payBase, input string tag);
    int xfers;
    xfers            = 0;
    in_header        = h;
    in_header_valid  = 1'b1;
    out_ready        = 1'b1;
    in_payload_valid = (nPay > 0);
    in_payload       = payBase;
    #1 checkOutput({tag, "_hrdy"}, 32'(in_header_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_header_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 expectOut($sformatf("%s_h%0d", tag, k), 1'b1, h[32*k +: 32], k == 0, (k == 2) && (nPay == 0));
      checkOutput({tag, "_prdy_hdr"}, 32'(in_payload_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < nPay; i++) begin
      in_payload = payBase + 32'(i);
      #1 expectOut($sformatf("%s_p%0d", tag, i), 1'b1, payBase + 32'(i), 1'b0, i == nPay - 1);
      if (in_payload_valid && in_payload_ready) xfers++;
      @(posedge clk); @(negedge clk);
    end
    in_payload_valid = 1'b0;
    #1 expectOut({tag, "_end"}, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput({tag, "_hrdy_end"}, 32'(in_header_ready), 32'd1);
    checkOutput({tag, "_prdy_end"}, 32'(in_payload_ready), 32'd0);
    if (nPay > 0) checkOutput({tag, "_xfers"}, 32'(xfers), 32'(nPay));
  endtask

  task automatic rejectHeader(input logic [95:0] h, input string tag);
    in_header       = h;
    in_header_valid = 1'b1;
    out_ready       = 1'b1;
    #1 checkOutput({tag, "_lerr_pre"}, 32'(len_error), 32'd0);
    @(posedge clk); @(negedge clk);
    in_header_valid = 1'b0;
    #1 checkOutput({tag, "_lerr"}, 32'(len_error), 32'd1);
    expectOut({tag, "_out"}, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput({tag, "_hrdy"}, 32'(in_header_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    #1 checkOutput({tag, "_lerr_off"}, 32'(len_error), 32'd0);
    expectOut({tag, "_out2"}, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst              = 1'b1;
    in_header        = {32'h3333_4444, 32'h1111_2222, 32'h4000_0002};
    in_header_valid  = 1'b1;
    in_payload       = 32'hDEAD_BEEF;
    in_payload_valid = 1'b1;
    out_ready        = 1'b1;

    // Everything quiet under reset even with valid inputs offered.
    #1 expectOut("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("rst_hrdy", 32'(in_header_ready), 32'd0);
    checkOutput("rst_prdy", 32'(in_payload_ready), 32'd0);
    checkOutput("rst_lerr", 32'(len_error), 32'd0);
    @(posedge clk); @(negedge clk);
    #1 expectOut("rst_clk", 1'b0, 32'd0, 1'b0, 1'b0);
    in_header_valid  = 1'b0;
    in_payload_valid = 1'b0;
    rst              = 1'b0;
    #1 checkOutput("post_rst_hrdy", 32'(in_header_ready), 32'd1);
    expectOut("post_rst", 1'b0, 32'd0, 1'b0, 1'b0);

    // Back-to-back TLPs of assorted fmt/Length combinations.
    applyStimulus({32'h3333_4444, 32'h1111_2222, 32'h0A00_0000}, 0, 32'h0, "nodata");
    applyStimulus({32'h0506_0708, 32'h0102_0304, 32'h4000_0004}, 4, 32'h0000_00A0, "data4");
    applyStimulus({32'h2222_0000, 32'h2121_0000, 32'h2000_0005}, 0, 32'h0, "fmt001");
    applyStimulus({32'h3131_0000, 32'h3030_0000, 32'h6000_0001}, 1, 32'h0000_0B00, "fmt011");
    applyStimulus({32'h4444_0000, 32'h4343_0000, 32'h0000_03FF}, 0, 32'h0, "nodata_len3ff");

    // Backpressure in HDR1 and PAYLOAD.
    in_header        = {32'hCCCC_0002, 32'hBBBB_0001, 32'h4000_0002};
    in_header_valid  = 1'b1;
    in_payload_valid = 1'b0;
    out_ready        = 1'b1;
    @(posedge clk); @(negedge clk);
    in_header_valid = 1'b0;
    #1 expectOut("bp_h0", 1'b1, 32'h4000_0002, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    #1 expectOut("bp_h1", 1'b1, 32'hBBBB_0001, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    #1 expectOut("bp_h1_hold", 1'b1, 32'hBBBB_0001, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    #1 expectOut("bp_h2", 1'b1, 32'hCCCC_0002, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    #1 expectOut("bp_pv0", 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("bp_prdy_pass", 32'(in_payload_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_payload_valid = 1'b1;
    in_payload       = 32'h5A5A_0000;
    out_ready        = 1'b0;
    #1 expectOut("bp_p0_stall", 1'b1, 32'h5A5A_0000, 1'b0, 1'b0);
    checkOutput("bp_p0_prdy", 32'(in_payload_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    #1 expectOut("bp_p0_hold", 1'b1, 32'h5A5A_0000, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1 checkOutput("bp_p0_prdy_go", 32'(in_payload_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_payload = 32'h5A5A_0001;
    out_ready  = 1'b0;
    #1 expectOut("bp_p1_stall", 1'b1, 32'h5A5A_0001, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    #1 expectOut("bp_p1_hold", 1'b1, 32'h5A5A_0001, 1'b0, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_payload_valid = 1'b0;
    #1 expectOut("bp_end", 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("bp_hrdy_end", 32'(in_header_ready), 32'd1);

    // Length rejection, then recovery and the MAX_LEN boundary.
    rejectHeader({32'h0, 32'h0, 32'h4000_0011}, "len17");
    applyStimulus({32'h5555_0002, 32'h5555_0001, 32'h0C00_0000}, 0, 32'h0, "after_err");
    rejectHeader({32'h0, 32'h0, 32'h4000_0000}, "len0");
    applyStimulus({32'h6666_0002, 32'h6666_0001, 32'h4000_0010}, 16, 32'hC000_0000, "len16");

    // Reset after two of four payload DW.
    in_header        = {32'h7777_0003, 32'h6666_0002, 32'h4000_0004};
    in_header_valid  = 1'b1;
    in_payload_valid = 1'b1;
    in_payload       = 32'h0000_00E0;
    out_ready        = 1'b1;
    @(posedge clk); @(negedge clk);
    in_header_valid = 1'b0;
    #1 expectOut("mr_h0", 1'b1, 32'h4000_0004, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    #1 expectOut("mr_p0", 1'b1, 32'h0000_00E0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    in_payload = 32'h0000_00E1;
    @(posedge clk); @(negedge clk);
    in_payload = 32'h0000_00E2;
    #1 expectOut("mr_p2", 1'b1, 32'h0000_00E2, 1'b0, 1'b0);
    rst = 1'b1;
    #1 expectOut("mr_rst", 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("mr_rst_prdy", 32'(in_payload_ready), 32'd0);
    checkOutput("mr_rst_hrdy", 32'(in_header_ready), 32'd0);
    checkOutput("mr_rst_lerr", 32'(len_error), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("mr_rel_hrdy", 32'(in_header_ready), 32'd1);
    expectOut("mr_rel", 1'b0, 32'd0, 1'b0, 1'b0);
    in_payload_valid = 1'b0;
    applyStimulus({32'h9999_0002, 32'h9999_0001, 32'h0A00_0001}, 0, 32'h0, "mr_clean");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cpl_tx_serializer.md
CPL_TX_SERIALIZER -- requirements
Module: cpl_tx_serializer

Parameters
REQ-001 The block SHALL have parameter LINK_NUMBER, default 0, giving the link index; it is informational only and does not change behaviour.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, giving the maximum payload length in DW that the block accepts.

Interface
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_header  input  96  3-DW completion header: DW0=[31:0], DW1=[63:32], DW2=[95:64]; fmt=[31:29], Length=[9:0].
REQ-006 in_header_valid / in_header_ready  input / output  1 / 1  header handshake.
REQ-007 in_payload  input  32  payload DW from the subunit.
REQ-008 in_payload_valid / in_payload_ready  input / output  1 / 1  payload handshake.
REQ-009 out_data  output  32  DW toward the PCIe physical layer.
REQ-010 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-011 out_sop, out_eop  output  1 each  first DW and last DW of a TLP, qualified by out_valid.
REQ-012 len_error  output  1  one-cycle pulse when a header is rejected.

Function
REQ-013 A transfer SHALL occur on any interface only in a cycle where valid and ready are both high at the rising edge.
REQ-014 The FSM SHALL have the states IDLE, HDR0, HDR1, HDR2 and PAYLOAD.
REQ-015 In IDLE, in_header_ready SHALL be 1; in every other state it SHALL be 0.
REQ-016 An accepted header SHALL be registered, and HDR0 SHALL be entered on the next edge, so DW0 appears on out_data one cycle after header acceptance.
REQ-017 The block SHALL classify a header as with-data when fmt[1]=1; its payload count is then Length, with Length 0 treated as 1024.
REQ-018 A with-data header whose payload count is greater than MAX_LEN SHALL be consumed, SHALL pulse len_error for 1 cycle, and SHALL leave the FSM in IDLE with no output.
REQ-019 In HDR0, HDR1 and HDR2, out_valid SHALL be 1 and out_data SHALL be DW0, DW1 and DW2 respectively.
REQ-020 The FSM SHALL advance from each HDR state only when out_ready=1, and SHALL hold the current DW stable while out_ready=0.
REQ-021 out_sop SHALL be 1 only in HDR0.
REQ-022 For a no-data header, out_eop SHALL be 1 in HDR2, and the FSM SHALL go to IDLE on the HDR2 transfer.
REQ-023 For a with-data header, the FSM SHALL go from HDR2 to PAYLOAD on transfer, with the down-counter loaded to the payload count.
REQ-024 In PAYLOAD, the block SHALL pass data through combinationally: out_data=in_payload, out_valid=in_payload_valid, in_payload_ready=out_ready.
REQ-025 Each PAYLOAD transfer SHALL decrement the counter by 1.
REQ-026 out_eop SHALL be 1 in PAYLOAD when the counter equals 1; that transfer SHALL return the FSM to IDLE.
REQ-027 The counter SHALL be 11 bits wide and SHALL never wrap below 0.
REQ-028 in_payload_ready SHALL be 0 outside PAYLOAD, and payload offered then SHALL NOT be consumed.
REQ-029 Whenever out_valid=0, out_data SHALL be 0 and out_sop and out_eop SHALL be 0.
REQ-030 Back-to-back TLPs SHALL be separated by exactly one IDLE cycle when all valid and ready inputs are held high.
REQ-031 A 3-DW no-data completion SHALL occupy 3 output cycles; a completion carrying N DW of payload SHALL occupy 3+N output cycles when out_ready=1 continuously.

Reset
REQ-032 While rst=1, the state SHALL be IDLE and the counter and header register SHALL be 0.
REQ-033 While rst=1, out_valid, out_sop, out_eop, len_error, in_header_ready, in_payload_ready and out_data SHALL all be 0, regardless of clk.
REQ-034 Asserting rst mid-TLP SHALL abandon that TLP with no out_eop, and the first cycle after rst falls SHALL be IDLE with in_header_ready=1.

Verification
REQ-035 No-data completion: fmt=000, header 0x..._00000000 accepted, out_ready=1 -> DW0/DW1/DW2 on 3 consecutive cycles starting 1 cycle later; sop on DW0, eop on DW2.
REQ-036 Data completion: fmt=010, Length=4, payload 0xA0..0xA3 -> 7 output DW with sop on DW0 and eop on 0xA3; in_payload_ready high for exactly 4 transfers.
REQ-037 Backpressure: out_ready toggles 1/0 during HDR1 and PAYLOAD -> no DW lost or duplicated, data held stable while stalled.
REQ-038 Length error: fmt=010, Length=17 with MAX_LEN=16 -> len_error pulses once, out_valid stays 0, and the next valid header is serialized normally.
REQ-039 Length 0 with data: fmt=010, Length=0 -> rejected with len_error, since 1024 > MAX_LEN.
REQ-040 Reset mid-payload: rst asserted after 2 of 4 payload DW -> all outputs 0 immediately, no eop; after release, a new no-data header produces a clean 3-DW TLP.
